// File: rtl/lag_link_credit_tracker.sv
// Per-(trunk, link) credit counters for a LAG router output stage, producing the
// registered link-blocked vector. Define LAG_CREDIT_ERR_CHECK_EN to get sticky error flags.
module lag_link_credit_tracker #(
    parameter int WA             = 5,
    parameter int WB             = 2,
    parameter int links [WA][2]  = '{default: 2},
    parameter int BUF_DEPTH      = 4,
    localparam int CNT_W         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flit_sent,
    input  logic [WA-1:0]             sent_trunk,
    input  logic [WB-1:0]             sent_link,
    input  logic [WA*WB-1:0]          credit_in,
    output logic [WA*WB-1:0]          blocked_out,
    output logic [WA*WB*CNT_W-1:0]    credit_cnt,
    output logic                      err_underflow,
    output logic                      err_overflow,
    output logic                      err_sel
);

    localparam int K   = WA * WB;
    localparam int OUT = 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    function automatic logic [K-1:0] pop_mask();
        logic [K-1:0] m;
        m = '0;
        for (int i = 0; i < WA; i++) begin
            for (int j = 0; j < WB; j++) begin
                m[i*WB+j] = (j < links[i][OUT]);
            end
        end
        return m;
    endfunction

    localparam logic [K-1:0] POP = pop_mask();

    logic                     sel_ok_s;
    logic [K-1:0]             dec_s;
    logic [K-1:0]             inc_s;
    logic [K-1:0][CNT_W-1:0]  cnt_d, cnt_q;
    logic [K-1:0]             blocked_d, blocked_q;

    // Decode departure/return pulses onto populated links only; malformed selects move nothing.
    always_comb begin
        sel_ok_s = $onehot(sent_trunk) && $onehot(sent_link);
        dec_s    = '0;
        inc_s    = '0;
        for (int i = 0; i < WA; i++) begin
            for (int j = 0; j < WB; j++) begin
                dec_s[i*WB+j] = flit_sent & sent_trunk[i] & sent_link[j] & sel_ok_s & POP[i*WB+j];
                inc_s[i*WB+j] = credit_in[i*WB+j] & POP[i*WB+j];
            end
        end
    end

    // Saturating counter update; a simultaneous send and return cancel out.
    always_comb begin
        cnt_d     = cnt_q;
        blocked_d = '0;
        for (int k = 0; k < K; k++) begin
            if (!POP[k]) begin
                cnt_d[k] = '0;
            end else if (dec_s[k] && !inc_s[k] && (cnt_q[k] != '0)) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end else if (inc_s[k] && !dec_s[k] && (cnt_q[k] != FULL)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else begin
                cnt_d[k] = cnt_q[k];
            end
            blocked_d[k] = (cnt_d[k] == '0);
        end
    end

    // Counter and blocked-status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                cnt_q[k] <= POP[k] ? FULL : '0;
            end
            blocked_q <= ~POP;
        end else begin
            cnt_q     <= cnt_d;
            blocked_q <= blocked_d;
        end
    end

    assign credit_cnt  = cnt_q;
    assign blocked_out = blocked_q;

`ifdef LAG_CREDIT_ERR_CHECK_EN
    logic [K-1:0] zero_s, full_s;
    logic         uf_ev_s, of_ev_s, sel_ev_s;
    logic         err_uf_d, err_of_d, err_sel_d;
    logic         err_uf_q, err_of_q, err_sel_q;

    // Error events: lone send at zero, lone return at full, or a non-one-hot select.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            zero_s[k] = (cnt_q[k] == '0);
            full_s[k] = (cnt_q[k] == FULL);
        end
        uf_ev_s   = |(dec_s & ~inc_s & zero_s);
        of_ev_s   = |(inc_s & ~dec_s & full_s);
        sel_ev_s  = flit_sent & ~sel_ok_s;
        err_uf_d  = err_uf_q | uf_ev_s;
        err_of_d  = err_of_q | of_ev_s;
        err_sel_d = err_sel_q | sel_ev_s;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_uf_q  <= 1'b0;
            err_of_q  <= 1'b0;
            err_sel_q <= 1'b0;
        end else begin
            err_uf_q  <= err_uf_d;
            err_of_q  <= err_of_d;
            err_sel_q <= err_sel_d;
`ifndef SYNTHESIS
            if (uf_ev_s)  $error("lag_link_credit_tracker: credit underflow");
            if (of_ev_s)  $error("lag_link_credit_tracker: credit overflow");
            if (sel_ev_s) $error("lag_link_credit_tracker: non-one-hot select");
`endif
        end
    end

    assign err_underflow = err_uf_q;
    assign err_overflow  = err_of_q;
    assign err_sel       = err_sel_q;
`else
    assign err_underflow = 1'b0;
    assign err_overflow  = 1'b0;
    assign err_sel       = 1'b0;
`endif

endmodule
